// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of one shared single-ported memory
// Define ARB_PERF_CNT_EN to add the perf_i_gnt / perf_d_gnt / perf_conflict counters.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                err_spur
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]         perf_i_gnt,
   output logic [31:0]         perf_d_gnt,
   output logic [31:0]         perf_conflict
`endif
);

   localparam int BE_W = DATA_W / 8;
   localparam int SW   = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t            state_q, state_d;
   logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
   logic              owner_d_q, owner_d_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [BE_W-1:0]   mem_be_q, mem_be_d;
   logic              i_rvalid_q, i_rvalid_d;
   logic              d_rvalid_q, d_rvalid_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              err_spur_q, err_spur_d;
   logic              d_win, i_win;

   // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
   always_comb begin
      d_win = (state_q == IDLE) && d_req && !(i_req && (starve_cnt_q == LIMIT));
      i_win = (state_q == IDLE) && i_req && !d_win;
   end

   assign i_gnt = i_win;
   assign d_gnt = d_win;

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      owner_d_d    = owner_d_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;
      i_rvalid_d   = 1'b0;
      d_rvalid_d   = 1'b0;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      err_spur_d   = err_spur_q;
      case (state_q)
         IDLE: begin
            if (mem_rvalid) err_spur_d = 1'b1;
            if (d_win) begin
               owner_d_d   = 1'b1;
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_be_d    = d_be;
               state_d     = ISSUE;
               if (!i_req) starve_cnt_d = '0;
               else if (starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + SW'(1);
            end else if (i_win) begin
               owner_d_d    = 1'b0;
               mem_req_d    = 1'b1;
               mem_we_d     = 1'b0;
               mem_addr_d   = i_addr;
               mem_wdata_d  = '0;
               mem_be_d     = '1;
               starve_cnt_d = '0;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            // A response overlapping the handshake cannot belong to this request.
            if (mem_rvalid) err_spur_d = 1'b1;
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               state_d   = RESP;
            end
         end
         RESP: begin
            if (mem_rvalid) begin
               if (owner_d_q) begin
                  d_rvalid_d = 1'b1;
                  d_rdata_d  = mem_we_q ? '0 : mem_rdata;
               end else begin
                  i_rvalid_d = 1'b1;
                  i_rdata_d  = mem_rdata;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         owner_d_q    <= 1'b1;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= '0;
         i_rvalid_q   <= 1'b0;
         d_rvalid_q   <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         err_spur_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         owner_d_q    <= owner_d_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
         i_rvalid_q   <= i_rvalid_d;
         d_rvalid_q   <= d_rvalid_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         err_spur_q   <= err_spur_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign i_rvalid  = i_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign err_spur  = err_spur_q;

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_i_gnt_q, perf_i_gnt_d;
   logic [31:0] perf_d_gnt_q, perf_d_gnt_d;
   logic [31:0] perf_conflict_q, perf_conflict_d;

   always_comb begin
      perf_i_gnt_d    = perf_i_gnt_q + (i_win ? 32'd1 : 32'd0);
      perf_d_gnt_d    = perf_d_gnt_q + (d_win ? 32'd1 : 32'd0);
      perf_conflict_d = perf_conflict_q +
                        ((state_q == IDLE) && i_req && d_req ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_i_gnt_q    <= '0;
         perf_d_gnt_q    <= '0;
         perf_conflict_q <= '0;
      end else begin
         perf_i_gnt_q    <= perf_i_gnt_d;
         perf_d_gnt_q    <= perf_d_gnt_d;
         perf_conflict_q <= perf_conflict_d;
      end
   end

   assign perf_i_gnt    = perf_i_gnt_q;
   assign perf_d_gnt    = perf_d_gnt_q;
   assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Define ARB_PERF_CNT_EN to also check the performance counters.
module tb_mem_port_arbiter;

   localparam int LIMIT = 4;

   logic        clk;
   logic        rst_n;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [3:0]  d_be;
   logic        i_gnt, d_gnt, i_rvalid, d_rvalid;
   logic [31:0] i_rdata, d_rdata;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        err_spur;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_i_gnt, perf_d_gnt, perf_conflict;
`endif

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .err_spur(err_spur)
`ifdef ARB_PERF_CNT_EN
      , .perf_i_gnt(perf_i_gnt), .perf_d_gnt(perf_d_gnt), .perf_conflict(perf_conflict)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // expected response owed to the requester on the next sampled cycle
   bit          pend;
   bit          pend_d;
   logic [31:0] pend_rd;

   // reference model: data grants that made a waiting fetch wait again
   logic [31:0] starved_by [$];
   int m_pi, m_pd, m_pc;

   typedef struct {
      bit          ir, dr, we;
      logic [31:0] ia, da, wd;
      logic [3:0]  be;
      int          gw, rw;
      logic [31:0] rd;
      bit          xd, xi;
      logic [31:0] xaddr;
      logic [3:0]  xbe;
      logic [31:0] xrd;
   } vec_t;

   vec_t tbl [8];
   bit   exp_order [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      pend = 1'b0;
      starved_by.delete();
      m_pi = 0;
      m_pd = 0;
      m_pc = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      i_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      clear_model();
   endtask

   task automatic sample(input bit idle);
      @(negedge clk);
      chk("i_rvalid", 32'(i_rvalid), 32'(pend && !pend_d));
      chk("d_rvalid", 32'(d_rvalid), 32'(pend && pend_d));
      if (pend) chk(pend_d ? "d_rdata" : "i_rdata", pend_d ? d_rdata : i_rdata, pend_rd);
      pend = 1'b0;
      if (!idle) begin
         chk("i_gnt_busy", 32'(i_gnt), 32'd0);
         chk("d_gnt_busy", 32'(d_gnt), 32'd0);
      end
   endtask

   // Starts just after a rising edge with the DUT idle; returns just after the
   // edge on which the owner's rvalid appears, leaving that check pending.
   task automatic txn(input bit ir, input bit dr, input bit we,
                      input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                      input logic [3:0] be, input int gw, input int rw, input logic [31:0] rd,
                      input bit sg, input bit xd, input bit xi,
                      input logic [31:0] xaddr, input logic [3:0] xbe, input logic [31:0] xrd);
      i_req = ir; i_addr = ia;
      d_req = dr; d_we = we; d_addr = da; d_wdata = wd; d_be = be;
      sample(1'b1);
      chk("i_gnt", 32'(i_gnt), 32'(xi));
      chk("d_gnt", 32'(d_gnt), 32'(xd));
      chk("mem_req_idle", 32'(mem_req), 32'd0);
      m_pi += int'(xi);
      m_pd += int'(xd);
      m_pc += int'(ir && dr);
      @(posedge clk);
      #1;
      if (xd || xi) begin
         if (xd) d_req = 1'b0;
         else    i_req = 1'b0;
         for (int c = 0; c <= gw; c++) begin
            mem_gnt    = (c == gw);
            mem_rvalid = (c == gw) && sg;
            sample(1'b0);
            chk("mem_req", 32'(mem_req), 32'd1);
            chk("mem_addr", mem_addr, xaddr);
            chk("mem_we", 32'(mem_we), 32'(xd && we));
            chk("mem_be", 32'(mem_be), 32'(xbe));
            if (xd) chk("mem_wdata", mem_wdata, wd);
            @(posedge clk);
            #1;
         end
         mem_gnt = 1'b0;
         for (int c = 0; c <= rw; c++) begin
            mem_rvalid = (c == rw);
            mem_rdata  = rd;
            sample(1'b0);
            chk("mem_req_resp", 32'(mem_req), 32'd0);
            @(posedge clk);
            #1;
         end
         mem_rvalid = 1'b0;
         pend    = 1'b1;
         pend_d  = xd;
         pend_rd = xrd;
      end
   endtask

   task automatic flush();
      i_req = 1'b0;
      d_req = 1'b0;
      sample(1'b1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0, 0, 1, 32'hDEADBEEF,
                 1'b0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h40, 32'h12345678, 4'b0011, 0, 0, 32'hFFFFFFFF,
                 1'b1, 1'b0, 32'h40, 4'b0011, 32'h0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h44, 32'h55555555, 4'hF, 3, 0, 32'hCAFEF00D,
                 1'b1, 1'b0, 32'h44, 4'hF, 32'hCAFEF00D};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h104, 32'h48, 32'h0, 4'hC, 1, 2, 32'h0BADC0DE,
                 1'b1, 1'b0, 32'h48, 4'hC, 32'h0BADC0DE};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h108, 32'h0, 32'h0, 4'h1, 2, 0, 32'h13579BDF,
                 1'b0, 1'b1, 32'h108, 4'hF, 32'h13579BDF};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0,
                 1'b0, 1'b0, 32'h0, 4'h0, 32'h0};
      tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h10C, 32'h4C, 32'hA5A5A5A5, 4'hF, 0, 3, 32'h77777777,
                 1'b1, 1'b0, 32'h4C, 4'hF, 32'h0};
      tbl[7] = '{1'b1, 1'b0, 1'b1, 32'h10C, 32'h0, 32'h0, 4'h6, 0, 0, 32'h2468ACE0,
                 1'b0, 1'b1, 32'h10C, 4'hF, 32'h2468ACE0};
      exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      rst_n = 1'b0;
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      clear_model();
      #3;
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_gnt", 32'({i_gnt, d_gnt}), 32'd0);
      chk("rst_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
      chk("rst_err_spur", 32'(err_spur), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      do_reset();

      for (int k = 0; k < 8; k++)
         txn(tbl[k].ir, tbl[k].dr, tbl[k].we, tbl[k].ia, tbl[k].da, tbl[k].wd, tbl[k].be,
             tbl[k].gw, tbl[k].rw, tbl[k].rd, 1'b0,
             tbl[k].xd, tbl[k].xi, tbl[k].xaddr, tbl[k].xbe, tbl[k].xrd);
      flush();
      chk("err_spur_clean", 32'(err_spur), 32'd0);

      // response arriving together with mem_gnt is not a response
      txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h60, 32'h0, 4'hF, 0, 1, 32'h11112222, 1'b1,
          1'b1, 1'b0, 32'h60, 4'hF, 32'h11112222);
      flush();
      chk("err_spur_overlap", 32'(err_spur), 32'd1);

      // reset in RESP, then a late response
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_be = 4'hF;
      sample(1'b1);
      chk("r5_d_gnt", 32'(d_gnt), 32'd1);
      @(posedge clk);
      #1 d_req = 1'b0; mem_gnt = 1'b1;
      sample(1'b0);
      @(posedge clk);
      #1 mem_gnt = 1'b0;
      sample(1'b0);
      chk("r5_resp_mem_req", 32'(mem_req), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("r5_rst_mem_req", 32'(mem_req), 32'd0);
      chk("r5_rst_mem_addr", mem_addr, 32'd0);
      chk("r5_rst_err", 32'(err_spur), 32'd0);
      clear_model();
      @(posedge clk);
      #1 rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h99999999;
      sample(1'b1);
      @(posedge clk);
      #1 mem_rvalid = 1'b0;
      sample(1'b1);
      chk("r5_err_set", 32'(err_spur), 32'd1);
      chk("r5_d_rdata", d_rdata, 32'd0);
      @(posedge clk);
      #1;

      // both requesters held high with a zero-wait memory
      for (int k = 0; k < 10; k++)
         txn(1'b1, 1'b1, 1'b0, 32'h200 + 32'(k * 4), 32'h300 + 32'(k * 4), 32'h0, 4'hF, 0, 0,
             32'hA000_0000 + 32'(k), 1'b0, exp_order[k], !exp_order[k],
             exp_order[k] ? 32'h300 + 32'(k * 4) : 32'h200 + 32'(k * 4), 4'hF,
             32'hA000_0000 + 32'(k));
      flush();
      chk("err_spur_sticky", 32'(err_spur), 32'd1);
`ifdef ARB_PERF_CNT_EN
      chk("perf_d_gnt_t2", perf_d_gnt, 32'd8);
      chk("perf_i_gnt_t2", perf_i_gnt, 32'd2);
      chk("perf_conflict_t2", perf_conflict, 32'd10);
`endif

      do_reset();
      chk("err_spur_cleared", 32'(err_spur), 32'd0);

      for (int n = 0; n < 150; n++) begin
         bit          ir, dr, we, xd, xi;
         logic [31:0] ia, da, wd, rd;
         logic [3:0]  be;
         int          gw, rw;
         ir = ($urandom_range(0, 3) != 0);
         dr = ($urandom_range(0, 3) != 0);
         we = 1'($urandom_range(0, 1));
         ia = $urandom; da = $urandom; wd = $urandom; rd = $urandom;
         be = 4'($urandom_range(0, 15));
         gw = int'($urandom_range(0, 3));
         rw = int'($urandom_range(0, 3));
         xd = dr && !(ir && starved_by.size() >= LIMIT);
         xi = ir && !xd;
         if (xd && ir) starved_by.push_back(da);
         else if (xd || xi) starved_by.delete();
         txn(ir, dr, we, ia, da, wd, be, gw, rw, rd, 1'b0, xd, xi,
             xd ? da : ia, xd ? be : 4'hF, (xd && we) ? 32'h0 : rd);
      end
      flush();
      chk("err_spur_random", 32'(err_spur), 32'd0);
`ifdef ARB_PERF_CNT_EN
      chk("perf_i_gnt_rand", perf_i_gnt, 32'(m_pi));
      chk("perf_d_gnt_rand", perf_d_gnt, 32'(m_pd));
      chk("perf_conflict_rand", perf_conflict, 32'(m_pc));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
